multi_channel_delay_timer: RTL and testbench

- N-channel, parametrised delay timer. Each channel counts cycles while its enable is held and fires when the count reaches a programmed bound.
- Each channel has a selectable output mode: level, single pulse or periodic.
- Per-channel bounds and modes are loaded through a shared config write port, with sticky fired-status bits.
- Sits between control FSMs and the peripherals that need timed strobes or delays.

---
 rtl/delay_timer_pkg.sv | 23 ++
 rtl/delay_timer_channel.sv | 113 +++++++++++
 rtl/multi_channel_delay_timer.sv | 67 ++++++
 tb/tb_multi_channel_delay_timer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/delay_timer_pkg.sv
// Shared types and helpers for the multi-channel delay timer.
// Mode and state encodings are visible to both the channel and the top.
package delay_timer_pkg;

    typedef enum logic [1:0] {
        LEVEL    = 2'b00,
        PULSE    = 2'b01,
        PERIODIC = 2'b10,
        RSVD     = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        COUNT = 2'b01,
        FIRED = 2'b10
    } state_e;

    // Width of a channel index; never below one bit so a single channel still has a port.
    function automatic int CH_IDX_W(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/delay_timer_channel.sv
// One timer channel: state machine, cycle counter, bound/mode registers and sticky fired bit.
// Bound/mode are only written while the channel is idle, so the running compare never sees a change.
module delay_timer_channel
    import delay_timer_pkg::*;
#(
    parameter int          CNT_W         = 32,
    parameter int unsigned DEFAULT_BOUND = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    input  logic             i_wr,
    input  logic [CNT_W-1:0] i_bound,
    input  logic [1:0]       i_mode,
    input  logic             i_clr,
    output logic             o_out,
    output logic             o_fired,
    output state_e           o_state
);

    state_e           r_state;
    mode_e            r_mode;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_bound;
    logic             r_out;
    logic             r_fired;
    logic             w_fire;

    // A fire event is any edge that lands the channel in FIRED with en still high.
    always_comb begin
        w_fire = 1'b0;
        case (r_state)
            IDLE:    w_fire = i_en && (r_bound == '0);
            COUNT:   w_fire = i_en && (r_count == r_bound);
            FIRED:   w_fire = i_en && (r_mode == PERIODIC) && (r_bound == '0);
            default: w_fire = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_count <= '0;
            r_bound <= CNT_W'(DEFAULT_BOUND);
            r_mode  <= LEVEL;
            r_out   <= 1'b0;
            r_fired <= 1'b0;
        end else begin
            if (i_wr) begin
                r_bound <= i_bound;
                r_mode  <= mode_e'(i_mode);
            end
            // Set beats clear when both land on the same edge.
            r_fired <= w_fire | (r_fired & ~i_clr);
            case (r_state)
                IDLE: begin
                    if (i_en) begin
                        if (r_bound == '0) begin
                            r_state <= FIRED;
                            r_out   <= 1'b1;
                        end else begin
                            r_state <= COUNT;
                            r_count <= CNT_W'(1);
                        end
                    end
                end
                COUNT: begin
                    if (!i_en) begin
                        r_state <= IDLE;
                        r_count <= '0;
                        r_out   <= 1'b0;
                    end else if (r_count == r_bound) begin
                        r_state <= FIRED;
                        r_out   <= 1'b1;
                    end else begin
                        r_count <= r_count + CNT_W'(1);
                    end
                end
                FIRED: begin
                    if (!i_en) begin
                        r_state <= IDLE;
                        r_count <= '0;
                        r_out   <= 1'b0;
                    end else begin
                        case (r_mode)
                            PULSE: r_out <= 1'b0;
                            PERIODIC: begin
                                if (r_bound == '0) begin
                                    r_out <= 1'b1;
                                end else begin
                                    r_state <= COUNT;
                                    r_count <= CNT_W'(1);
                                    r_out   <= 1'b0;
                                end
                            end
                            default: r_out <= 1'b1;
                        endcase
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_count <= '0;
                    r_out   <= 1'b0;
                end
            endcase
        end
    end

    assign o_out   = r_out;
    assign o_fired = r_fired;
    assign o_state = r_state;

endmodule

// File: rtl/multi_channel_delay_timer.sv
// N independent delay-timer channels behind a shared config write port.
// A write is only taken by an idle channel whose enable is low; anything else flags cfg_err.
module multi_channel_delay_timer
    import delay_timer_pkg::*;
#(
    parameter int          N_CH          = 4,
    parameter int          CNT_W         = 32,
    parameter int unsigned DEFAULT_BOUND = 1000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_CH-1:0]               en,
    input  logic                          cfg_we,
    input  logic [CH_IDX_W(N_CH)-1:0]     cfg_ch,
    input  logic [CNT_W-1:0]              cfg_bound,
    input  logic [1:0]                    cfg_mode,
    output logic                          cfg_err,
    input  logic [N_CH-1:0]               status_clr,
    output logic [N_CH-1:0]               timer_out,
    output logic [N_CH-1:0]               fired_status,
    output logic [N_CH-1:0]               busy
);

    localparam int CH_W = CH_IDX_W(N_CH);

    state_e            w_state [N_CH];
    logic [N_CH-1:0]   w_wr_sel;
    logic              r_cfg_err;

    // Out-of-range channel numbers match no select bit and therefore fall through to an error.
    always_comb begin
        w_wr_sel = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_wr_sel[i] = cfg_we && (cfg_ch == CH_W'(i)) && !en[i] && (w_state[i] == IDLE);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= cfg_we && (w_wr_sel == '0);
        end
    end

    assign cfg_err = r_cfg_err;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        delay_timer_channel #(
            .CNT_W         (CNT_W),
            .DEFAULT_BOUND (DEFAULT_BOUND)
        ) u_ch (
            .clk     (clk),
            .reset   (reset),
            .i_en    (en[g]),
            .i_wr    (w_wr_sel[g]),
            .i_bound (cfg_bound),
            .i_mode  (cfg_mode),
            .i_clr   (status_clr[g]),
            .o_out   (timer_out[g]),
            .o_fired (fired_status[g]),
            .o_state (w_state[g])
        );
        assign busy[g] = (w_state[g] != IDLE);
    end

endmodule

// File: tb/tb_multi_channel_delay_timer.sv
// Bench for multi_channel_delay_timer: directed scenarios plus random traffic, all outputs
// compared every cycle against a run-length model of each channel.
module tb_multi_channel_delay_timer;
    import delay_timer_pkg::*;

    localparam int N_CH          = 5;
    localparam int CNT_W         = 32;
    localparam int DEFAULT_BOUND = 1000;
    localparam int CH_W          = CH_IDX_W(N_CH);

    logic                clk = 1'b0;
    logic                reset;
    logic [N_CH-1:0]     en;
    logic                cfg_we;
    logic [CH_W-1:0]     cfg_ch;
    logic [CNT_W-1:0]    cfg_bound;
    logic [1:0]          cfg_mode;
    logic                cfg_err;
    logic [N_CH-1:0]     status_clr;
    logic [N_CH-1:0]     timer_out;
    logic [N_CH-1:0]     fired_status;
    logic [N_CH-1:0]     busy;

    int total = 0;
    int bad   = 0;

    // Model: m_k = number of consecutive edges en has been sampled high.
    longint           m_k     [N_CH];
    longint           m_bnd   [N_CH];
    logic [1:0]       m_mode  [N_CH];
    logic [N_CH-1:0]  m_out;
    logic [N_CH-1:0]  m_fired;
    logic             m_err;

    multi_channel_delay_timer #(
        .N_CH          (N_CH),
        .CNT_W         (CNT_W),
        .DEFAULT_BOUND (DEFAULT_BOUND)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .cfg_we       (cfg_we),
        .cfg_ch       (cfg_ch),
        .cfg_bound    (cfg_bound),
        .cfg_mode     (cfg_mode),
        .cfg_err      (cfg_err),
        .status_clr   (status_clr),
        .timer_out    (timer_out),
        .fired_status (fired_status),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit exp_out(longint k, longint b, logic [1:0] m);
        longint p = b + 1;
        if (k == 0) return 1'b0;
        case (m)
            2'b01:   return k == p;
            2'b10:   return (k % p) == 0;
            default: return k >= p;
        endcase
    endfunction

    function automatic bit exp_fire(longint k, longint b, logic [1:0] m);
        longint p = b + 1;
        if (k == 0) return 1'b0;
        if (m == 2'b10) return (k % p) == 0;
        return k == p;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N_CH; i++) begin
            m_k[i]    = 0;
            m_bnd[i]  = DEFAULT_BOUND;
            m_mode[i] = 2'b00;
        end
        m_out   = '0;
        m_fired = '0;
        m_err   = 1'b0;
    endtask

    task automatic model_edge();
        bit any_acc = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            bit acc;
            bit fire;
            acc  = cfg_we && (int'(cfg_ch) == i) && (m_k[i] == 0) && !en[i];
            m_k[i]     = en[i] ? m_k[i] + 1 : 0;
            m_out[i]   = exp_out(m_k[i], m_bnd[i], m_mode[i]);
            fire       = exp_fire(m_k[i], m_bnd[i], m_mode[i]);
            m_fired[i] = fire | (m_fired[i] & ~status_clr[i]);
            if (acc) begin
                m_bnd[i]  = longint'(cfg_bound);
                m_mode[i] = cfg_mode;
                any_acc   = 1'b1;
            end
        end
        m_err = cfg_we && !any_acc;
    endtask

    task automatic check_all();
        logic [N_CH-1:0] m_busy;
        for (int i = 0; i < N_CH; i++) m_busy[i] = (m_k[i] != 0);
        check("timer_out", 64'(timer_out), 64'(m_out));
        check("fired_status", 64'(fired_status), 64'(m_fired));
        check("busy", 64'(busy), 64'(m_busy));
        check("cfg_err", 64'(cfg_err), 64'(m_err));
    endtask

    // Inputs change 1 time unit after each rising edge and are sampled at the next one.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic cfg_write(input int ch, input logic [CNT_W-1:0] b, input logic [1:0] m);
        cfg_we    = 1'b1;
        cfg_ch    = CH_W'(ch);
        cfg_bound = b;
        cfg_mode  = m;
        tick();
        cfg_we    = 1'b0;
    endtask

    initial begin
        int rise;
        int hi;

        reset      = 1'b1;
        en         = '0;
        cfg_we     = 1'b0;
        cfg_ch     = '0;
        cfg_bound  = '0;
        cfg_mode   = 2'b00;
        status_clr = '0;
        #3;
        model_reset();
        check_all();
        @(negedge clk);
        reset = 1'b0;

        // Default bound, LEVEL: rise on the 1001st sampled edge and stay high.
        en[0] = 1'b1;
        rise  = -1;
        for (int c = 1; c <= 1005; c++) begin
            tick();
            if (timer_out[0] && rise < 0) rise = c;
        end
        check("ch0_rise_edge", 64'(rise), 64'(1001));
        en[0] = 1'b0;
        tick();

        // PULSE with bound 3: exactly one high cycle in 20.
        cfg_write(1, 3, 2'b01);
        en[1] = 1'b1;
        hi = 0;
        repeat (20) begin
            tick();
            hi += int'(timer_out[1]);
        end
        check("ch1_pulse_count", 64'(hi), 64'(1));
        en[1] = 1'b0;
        tick();

        // PERIODIC bound 2: four pulses in 12 cycles; bound 0: always high.
        cfg_write(2, 2, 2'b10);
        en[2] = 1'b1;
        hi = 0;
        repeat (12) begin
            tick();
            hi += int'(timer_out[2]);
        end
        check("ch2_periodic_count", 64'(hi), 64'(4));
        en[2] = 1'b0;
        tick();
        cfg_write(2, 0, 2'b10);
        en[2] = 1'b1;
        hi = 0;
        repeat (8) begin
            tick();
            hi += int'(timer_out[2]);
        end
        check("ch2_bound0_count", 64'(hi), 64'(8));
        en[2] = 1'b0;
        tick();

        // Rejected writes: busy channel, out-of-range channel, write coinciding with en rising.
        en[3] = 1'b1;
        tick();
        tick();
        cfg_write(3, 7, 2'b01);
        check("err_busy_ch", 64'(cfg_err), 64'(1));
        cfg_write(N_CH, 7, 2'b01);
        check("err_bad_ch", 64'(cfg_err), 64'(1));
        tick();
        en[3] = 1'b0;
        tick();
        cfg_write(3, 2, 2'b00);
        check("ok_idle_ch", 64'(cfg_err), 64'(0));
        en[3] = 1'b1;
        repeat (5) tick();
        en[3] = 1'b0;
        tick();
        en[3] = 1'b1;
        cfg_write(3, 9, 2'b01);
        check("err_en_rise", 64'(cfg_err), 64'(1));
        repeat (5) tick();
        en[3] = 1'b0;
        tick();

        // Sticky status: clear on a fire edge loses, clear on a quiet edge wins.
        cfg_write(4, 2, 2'b00);
        en[4] = 1'b1;
        tick();
        tick();
        status_clr[4] = 1'b1;
        tick();
        status_clr[4] = 1'b0;
        check("status_set_wins", 64'(fired_status[4]), 64'(1));
        tick();
        status_clr[4] = 1'b1;
        tick();
        status_clr[4] = 1'b0;
        check("status_cleared", 64'(fired_status[4]), 64'(0));
        en[4] = 1'b0;
        tick();

        // Random traffic with small bounds so every mode fires often.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N_CH; i++) begin
                if ($urandom_range(0, 7) == 0) en[i] = ~en[i];
                status_clr[i] = ($urandom_range(0, 7) == 0);
            end
            cfg_we    = ($urandom_range(0, 5) == 0);
            cfg_ch    = CH_W'($urandom_range(0, (1 << CH_W) - 1));
            cfg_bound = CNT_W'($urandom_range(0, 6));
            cfg_mode  = 2'($urandom_range(0, 3));
            tick();
        end
        cfg_we     = 1'b0;
        status_clr = '0;
        en         = '0;
        tick();

        // Maximum bound on every channel, then asynchronous reset mid-count.
        for (int i = 0; i < N_CH; i++) cfg_write(i, '1, 2'b10);
        en = '1;
        repeat (10) tick();
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        check("reset_busy_now", 64'(busy), 64'(0));
        en = '0;
        @(negedge clk);
        reset = 1'b0;

        // Bounds must be back to the default after reset.
        en   = '1;
        rise = -1;
        for (int c = 1; c <= 1003; c++) begin
            tick();
            if (timer_out[N_CH-1] && rise < 0) rise = c;
        end
        check("post_reset_rise_edge", 64'(rise), 64'(1001));
        en = '0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
